// File: rtl/pc_unit_ras.sv
// Program-counter unit with a circular return-address stack.
// Produces the registered fetch address. Supports sequential, branch, jump,
// call and return flows, plus exception redirect and stall. The RAS tracks
// occupancy and raises sticky overflow/underflow flags.
module pc_unit_ras #(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned IMM_W     = 7,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned PC_INC    = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             stall,
  input  logic [2:0]                       sel,
  input  logic [IMM_W-1:0]                 imm,
  input  logic [PC_W-1:0]                  alu_out,
  input  logic                             exc_valid,
  input  logic [PC_W-1:0]                  exc_vec,
  input  logic                             err_clr,
  output logic [PC_W-1:0]                  pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_ovf,
  output logic                             ras_udf
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH+1);

  typedef enum logic [2:0] {
    SEL_SEQ   = 3'b000,
    SEL_BR    = 3'b001,
    SEL_JR    = 3'b010,
    SEL_CALL  = 3'b011,
    SEL_RET   = 3'b100,
    SEL_CALLR = 3'b101
  } sel_e;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] tp_q, tp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [PC_W-1:0]  seq, imm_ext, rel;
  logic             push, full, empty, ovf_set, udf_set;
  sel_e             sel_op;

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];

  // Next-PC selection, RAS pointer/count update and sticky flag logic.
  always_comb begin
    sel_op  = sel_e'(sel);
    seq     = pc_q + PC_W'(PC_INC);
    imm_ext = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    rel     = seq + imm_ext;
    full    = (cnt_q == CNT_W'(RAS_DEPTH));
    empty   = (cnt_q == '0);

    pc_d    = pc_q;
    tp_d    = tp_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;

    if (exc_valid) begin
      pc_d = exc_vec;
    end else if (!stall) begin
      case (sel_op)
        SEL_BR:    pc_d = rel;
        SEL_JR:    pc_d = alu_out;
        SEL_CALL: begin
          push = 1'b1;
          pc_d = rel;
        end
        SEL_CALLR: begin
          push = 1'b1;
          pc_d = alu_out;
        end
        SEL_RET: begin
          if (empty) begin
            pc_d    = seq;
            udf_set = 1'b1;
          end else begin
            pc_d  = ras_mem[tp_q];
            tp_d  = tp_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default:   pc_d = seq;
      endcase
    end

    // A push into a full stack overwrites the oldest slot: the pointer still
    // advances, the count saturates.
    if (push) begin
      tp_d = tp_q + PTR_W'(1);
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    ovf_d = ovf_set | (ovf_q & ~err_clr);
    udf_d = udf_set | (udf_q & ~err_clr);
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= PC_W'(RESET_PC);
      tp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // RAS storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[tp_q + PTR_W'(1)] <= seq;
    end
  end

  assign pc        = pc_q;
  assign ras_count = cnt_q;
  assign ras_ovf   = ovf_q;
  assign ras_udf   = udf_q;

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
Parametrised program-counter unit that generates the fetch address each cycle. It supports sequential, PC-relative branch, register-indirect jump, call and return flows, plus exception redirect and pipeline stall. It includes a circular return-address stack (RAS) with occupancy and sticky error flags. It sits between the control decoder / ALU and the instruction memory address port.

Parameters:
PC_W, 16, PC and address width in bits
IMM_W, 7, branch/call offset width; two's complement, sign-extended to PC_W
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset
PC_INC, 1, sequential increment

Ports:
clk  in  1  clock
rst_n  in  1  reset
stall  in  1  hold PC and RAS this cycle
sel  in  3  next-PC select (encoding below)
imm  in  IMM_W  signed relative offset
alu_out  in  PC_W  register-indirect target
exc_valid  in  1  exception redirect request
exc_vec  in  PC_W  exception target
err_clr  in  1  clear sticky error flags
pc  out  PC_W  current fetch address
ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries
ras_ovf  out  1  sticky: push into full RAS
ras_udf  out  1  sticky: pop of empty RAS

Behaviour:
- Reset: clk rising-edge design; rst_n is asynchronous, active-low.
  - Reset values: pc=RESET_PC, ras_count=0, top pointer=0, ras_ovf=0, ras_udf=0.
  - RAS storage contents are don't-care after reset.
- Latency: pc is registered. A decision in cycle N appears on pc in cycle N+1.
- Derived values:
  - seq = pc+PC_INC
  - imm_ext = sign-extend(imm) to PC_W
  - All adds are modulo 2^PC_W; wrap-around is silent.
- sel encoding (unlisted codes behave as 000):
  - 000 SEQ: pc <= seq
  - 001 BR: pc <= seq + imm_ext
  - 010 JR: pc <= alu_out
  - 011 CALL: push seq; pc <= seq + imm_ext
  - 100 RET: pop; pc <= popped value
  - 101 CALLR: push seq; pc <= alu_out
- Priority (highest first): exc_valid > stall > sel.
  - exc_valid=1: pc <= exc_vec. RAS and flags are untouched. stall is ignored.
  - stall=1 (no exc): pc, RAS, pointer and ras_count hold. No push/pop, no flag update.
- RAS is a circular buffer with top pointer tp.
  - Push: write to entry tp+1 (mod DEPTH), tp advances. ras_count increments, saturating at RAS_DEPTH.
  - Push when ras_count==RAS_DEPTH: oldest entry is overwritten, ras_count stays RAS_DEPTH, ras_ovf <= 1.
  - Pop: read entry tp, tp decrements (mod DEPTH), ras_count decrements.
  - Pop when ras_count==0: pc <= seq (fall-through). Pointer and count unchanged. ras_udf <= 1.
- Flags: ras_ovf and ras_udf are sticky until err_clr=1 or reset.
  - err_clr clears both flags at the clock edge.
  - A new error in the same cycle as err_clr wins (flag stays set).
  - err_clr acts regardless of stall or exc_valid.
- Reset mid-operation: everything returns to reset values immediately, independent of clk.

Test Plan:
- Reset with rst_n=0 mid-cycle -> pc=0x0000 and ras_count=0 immediately, without a clock edge. After release, 3 SEQ cycles -> pc=1,2,3.
- At pc=0x0010: BR with imm=7'h7F (-1) -> pc=0x0010. Then BR with imm=7'h05 -> pc=0x0016. At pc=0xFFFF, SEQ -> pc=0x0000.
- At pc=0x0020: CALL imm=0x10 -> pc=0x0031, ras_count=1. Then CALLR alu_out=0x0100 -> pc=0x0100, ras_count=2. RET -> pc=0x0032. RET -> pc=0x0021, ras_count=0.
- Five consecutive CALLs with DEPTH=4 -> ras_count=4 and ras_ovf=1. Four RETs return the four newest addresses in LIFO order. A fifth RET gives pc=old pc+1 and ras_udf=1. err_clr=1 -> both flags 0.
- stall=1 with sel=CALL for 3 cycles -> pc and ras_count unchanged. Drop stall -> the call executes once.
- stall=1 with exc_valid=1 and exc_vec=0x0200 -> pc=0x0200 next cycle, ras_count unchanged. exc_valid with sel=RET -> no pop occurs.
